// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a stable PLL lock, then releases N_STAGES
// active-low reset domains one at a time, lowest bit first. Loss of lock,
// a debounced board button or a software request asserts every domain
// reset together on the next edge.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   HOLD    | all domains in reset, waiting for lock and no button
//   STABLE  | lock seen, counting LOCK_STABLE cycles before release
//   RELEASE | releasing one domain every STAGE_DELAY cycles
//   RUN     | every domain out of reset
module reset_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_STABLE = 256,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                locked_i,
  input  logic                ext_rst_n_i,
  input  logic                sw_rst_req_i,
  input  logic                clear_status_i,
  output logic [N_STAGES-1:0] rst_n_o,
  output logic                all_released_o,
  output logic                lock_lost_o,
  output logic [1:0]          state_o
);

  if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_n_stages
    $error("reset_sequencer: N_STAGES must be 1..8");
  end
  if (STAGE_DELAY < 1) begin : g_bad_stage_delay
    $error("reset_sequencer: STAGE_DELAY must be >= 1");
  end
  if (LOCK_STABLE < 1) begin : g_bad_lock_stable
    $error("reset_sequencer: LOCK_STABLE must be >= 1");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("reset_sequencer: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("reset_sequencer: DEBOUNCE must be >= 1");
  end

  // One counter serves both timed states, so it is sized for the longer one.
  localparam int CNT_MAX = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(DEBOUNCE + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE_DELAY - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                 locked_s;
  logic                 ext_s;
  logic [DW-1:0]        deb_cnt;
  logic                 ext_req;
  logic                 any_req;
  logic [N_STAGES-1:0]  rel_next;

  assign locked_s = lock_sync[SYNC_STAGES-1];
  assign ext_s    = ext_sync[SYNC_STAGES-1];
  assign any_req  = !locked_s || ext_req || sw_rst_req_i;
  // Next release pattern: shift in one more released domain from bit 0.
  assign rel_next = N_STAGES'({rst_n_o, 1'b1});
  assign state_o  = state;

  // Bring the asynchronous lock and button inputs into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= '0;
      ext_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_i};
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], ext_rst_n_i};
    end
  end

  // Button debounce: request after DEBOUNCE consecutive low cycles, drop on the first high.
  // The request is registered so an exactly-long-enough press is still seen by the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      ext_req <= 1'b0;
    end else if (ext_s) begin
      deb_cnt <= '0;
      ext_req <= 1'b0;
    end else if (deb_cnt == DEB_LAST) begin
      ext_req <= 1'b1;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // Sequencing FSM with registered reset outputs; any request collapses to HOLD at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HOLD;
      cnt            <= '0;
      rst_n_o        <= '0;
      all_released_o <= 1'b0;
    end else if (state != HOLD && any_req) begin
      state          <= HOLD;
      cnt            <= '0;
      rst_n_o        <= '0;
      all_released_o <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          cnt            <= '0;
          rst_n_o        <= '0;
          all_released_o <= 1'b0;
          if (locked_s && !ext_req) state <= STABLE;
        end
        STABLE: begin
          if (cnt == STABLE_LAST) begin
            cnt            <= '0;
            rst_n_o        <= N_STAGES'(1);
            all_released_o <= (N_STAGES == 1);
            state          <= (N_STAGES == 1) ? RUN : RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == STAGE_LAST) begin
            cnt            <= '0;
            rst_n_o        <= rel_next;
            all_released_o <= &rel_next;
            if (rel_next[N_STAGES-1]) state <= RUN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt            <= '0;
          rst_n_o        <= '1;
          all_released_o <= 1'b1;
        end
      endcase
    end
  end

  // Sticky lock-loss flag; a loss in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_lost_o <= 1'b0;
    end else if (!locked_s && state != HOLD) begin
      lock_lost_o <= 1'b1;
    end else if (clear_status_i) begin
      lock_lost_o <= 1'b0;
    end
  end

endmodule
